// File: rtl/qam_pkg.sv
// Shared constants and helpers for the QAM front-end blocks.
package qam_pkg;

  // Bits per symbol for the supported constellations.
  localparam int QAM_BPS_2  = 1;
  localparam int QAM_BPS_4  = 2;
  localparam int QAM_BPS_16 = 4;

  // Width of a counter that must hold 0..SYMS-1, where SYMS = dw/bps (min 1 bit).
  function automatic int syms_cnt_w(input int dw, input int bps);
    int s;
    s = dw / bps;
    return (s > 1) ? $clog2(s) : 1;
  endfunction

endpackage

// File: rtl/qam_symbol_tick.sv
// Symbol-rate strobe: one tick every PERIOD enabled cycles.
module qam_symbol_tick #(
  parameter int PERIOD = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_enable,
  output logic o_tick
);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_enable && w_last;

  // Count enabled cycles, wrapping on the tick.
  always_ff @(posedge i_clk) begin
    if (i_rst)         r_cnt <= '0;
    else if (i_enable) r_cnt <= w_last ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/qam_bit_serializer.sv
// Word-to-symbol serializer feeding a QAM mapper's select/signal_in.
// A one-word holding register lets the next word arrive while the current
// one is still being shifted out, so back-to-back words stream without gaps.
module qam_bit_serializer
  import qam_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int BITS_PER_SYMBOL = QAM_BPS_2,
  parameter int SYMBOL_PERIOD   = 1,
  parameter int MSB_FIRST       = 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_enable,
  input  logic [DATA_WIDTH-1:0]      i_s_data,
  input  logic                       i_s_valid,
  output logic                       o_s_ready,
  output logic                       o_select,
  output logic [BITS_PER_SYMBOL-1:0] o_symbol,
  output logic                       o_busy,
  output logic                       o_underrun
);
  localparam int SYMS = DATA_WIDTH / BITS_PER_SYMBOL;
  localparam int SCW  = syms_cnt_w(DATA_WIDTH, BITS_PER_SYMBOL);
  localparam int BPS  = BITS_PER_SYMBOL;

  // Elaboration-time parameter legality.
  if (BITS_PER_SYMBOL < 1 || DATA_WIDTH % BITS_PER_SYMBOL != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a positive multiple of BITS_PER_SYMBOL");
  end
  if (SYMBOL_PERIOD < 1) begin : g_bad_period
    $error("SYMBOL_PERIOD must be >= 1");
  end

  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_valid;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [SCW-1:0]        r_shift_cnt;
  logic                  r_select;
  logic [BPS-1:0]        r_symbol;
  logic                  r_underrun;
  logic                  r_last_emit;

  logic                  w_tick;
  logic                  w_shift_empty;
  logic                  w_accept;
  logic                  w_hold_take;
  logic [BPS-1:0]        w_hold_sym;
  logic [BPS-1:0]        w_shift_sym;
  logic [DATA_WIDTH-1:0] w_hold_rest;
  logic [DATA_WIDTH-1:0] w_shift_rest;

  qam_symbol_tick #(.PERIOD(SYMBOL_PERIOD)) u_tick (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_enable (i_enable),
    .o_tick   (w_tick)
  );

  assign w_shift_empty = (r_shift_cnt == '0);
  // Hold is drained into the shifter on a tick with an empty shifter.
  assign w_hold_take   = w_tick && w_shift_empty && r_hold_valid;
  assign o_s_ready     = !i_rst && (!r_hold_valid || (w_tick && w_shift_empty));
  assign w_accept      = i_s_valid && o_s_ready;

  // Symbol extraction and remainder alignment depend on send order.
  assign w_hold_sym   = (MSB_FIRST != 0) ? r_hold[DATA_WIDTH-1 -: BPS]  : r_hold[BPS-1:0];
  assign w_shift_sym  = (MSB_FIRST != 0) ? r_shift[DATA_WIDTH-1 -: BPS] : r_shift[BPS-1:0];
  assign w_hold_rest  = (MSB_FIRST != 0) ? (r_hold << BPS)  : (r_hold >> BPS);
  assign w_shift_rest = (MSB_FIRST != 0) ? (r_shift << BPS) : (r_shift >> BPS);

  // Holding register: a refill on the consuming edge keeps it valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
    end else if (w_accept) begin
      r_hold       <= i_s_data;
      r_hold_valid <= 1'b1;
    end else if (w_hold_take) begin
      r_hold_valid <= 1'b0;
    end
  end

  // Per-tick emit: shifter first, then hold, else flag starvation once.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift     <= '0;
      r_shift_cnt <= '0;
      r_select    <= 1'b0;
      r_symbol    <= '0;
      r_underrun  <= 1'b0;
      r_last_emit <= 1'b0;
    end else begin
      r_select   <= 1'b0;
      r_underrun <= 1'b0;
      if (w_tick) begin
        if (!w_shift_empty) begin
          r_select    <= 1'b1;
          r_symbol    <= w_shift_sym;
          r_shift     <= w_shift_rest;
          r_shift_cnt <= r_shift_cnt - 1'b1;
          r_last_emit <= 1'b1;
        end else if (r_hold_valid) begin
          r_select    <= 1'b1;
          r_symbol    <= w_hold_sym;
          r_shift     <= w_hold_rest;
          r_shift_cnt <= SCW'(SYMS - 1);
          r_last_emit <= 1'b1;
        end else begin
          r_underrun  <= r_last_emit;
          r_last_emit <= 1'b0;
        end
      end
    end
  end

  assign o_select   = r_select;
  assign o_symbol   = r_symbol;
  assign o_underrun = r_underrun;
  assign o_busy     = r_hold_valid || !w_shift_empty;
endmodule

// File: tb/tb_qam_bit_serializer.sv
// Directed bench for qam_bit_serializer: a 1-bit MSB-first instance at full
// symbol rate and a 2-bit LSB-first instance at one symbol per 4 cycles.
module tb_qam_bit_serializer;
  import qam_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       enA, enB;
  logic [7:0] dA, dB;
  logic       vA, vB;
  logic       rdyA, rdyB, selA, selB, busyA, busyB, undA, undB;
  logic       symA;
  logic [1:0] symB;

  int checks   = 0;
  int failures = 0;

  logic [31:0] qA[$];
  logic [31:0] qB[$];

  always #5 clk = ~clk;

  qam_bit_serializer #(
    .DATA_WIDTH(8), .BITS_PER_SYMBOL(QAM_BPS_2), .SYMBOL_PERIOD(1), .MSB_FIRST(1)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_enable(enA), .i_s_data(dA), .i_s_valid(vA),
    .o_s_ready(rdyA), .o_select(selA), .o_symbol(symA), .o_busy(busyA),
    .o_underrun(undA)
  );

  qam_bit_serializer #(
    .DATA_WIDTH(8), .BITS_PER_SYMBOL(QAM_BPS_4), .SYMBOL_PERIOD(4), .MSB_FIRST(0)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_enable(enB), .i_s_data(dB), .i_s_valid(vB),
    .o_s_ready(rdyB), .o_select(selB), .o_symbol(symB), .o_busy(busyB),
    .o_underrun(undB)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: every strobe pops the oldest expected symbol.
  always @(negedge clk) begin
    if (selA === 1'b1) begin
      chk("a_strobe_has_expect", 32'(qA.size() != 0), 32'd1);
      if (qA.size() != 0) chk("a_symbol", 32'(symA), qA.pop_front());
    end
    if (selB === 1'b1) begin
      chk("b_strobe_has_expect", 32'(qB.size() != 0), 32'd1);
      if (qB.size() != 0) chk("b_symbol", 32'(symB), qB.pop_front());
    end
  end

  // Present a word and hold it until the handshake edge; returns 1ns after it.
  task automatic send_a(input logic [7:0] d);
    int n;
    n = 0;
    dA = d; vA = 1'b1;
    #1;
    while (rdyA !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("a_accept", 32'(rdyA), 32'd1);
    @(posedge clk); #1;
    vA = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d);
    int n;
    n = 0;
    dB = d; vB = 1'b1;
    #1;
    while (rdyB !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("b_accept", 32'(rdyB), 32'd1);
    @(posedge clk); #1;
    vB = 1'b0;
  endtask

  task automatic push_a(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) qA.push_back(32'(d[i]));
  endtask

  task automatic strobes_a(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_select"}, 32'(selA), 32'd1);
      chk({tag, "_no_underrun"}, 32'(undA), 32'd0);
    end
  endtask

  task automatic underrun_a(input string tag);
    @(negedge clk);
    chk({tag, "_underrun"}, 32'(undA), 32'd1);
    chk({tag, "_idle_select"}, 32'(selA), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busyA), 32'd0);
    @(negedge clk);
    chk({tag, "_underrun_one_cycle"}, 32'(undA), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; enA = 1'b1; enB = 1'b1;
    vA = 1'b1; dA = 8'hFF; vB = 1'b1; dB = 8'hFF;

    // Reset held 3 cycles with valid asserted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", 32'(rdyA), 32'd0);
      chk("rst_select", 32'(selA), 32'd0);
      chk("rst_busy", 32'(busyA), 32'd0);
      chk("rst_underrun", 32'(undA), 32'd0);
      chk("rst_ready_b", 32'(rdyB), 32'd0);
    end
    rst = 1'b0; vA = 1'b0; vB = 1'b0;
    @(negedge clk);
    chk("idle_no_underrun", 32'(undA), 32'd0);
    chk("idle_ready", 32'(rdyA), 32'd1);

    // Single word A5, MSB first
    push_a(8'hA5);
    send_a(8'hA5);
    @(negedge clk);
    chk("a5_lat_select", 32'(selA), 32'd0);
    chk("a5_lat_underrun", 32'(undA), 32'd0);
    chk("a5_lat_busy", 32'(busyA), 32'd1);
    strobes_a("a5", 8);
    underrun_a("a5");

    // Back-to-back FF, 00: second word refills hold on the first emit edge
    push_a(8'hFF); push_a(8'h00);
    send_a(8'hFF);
    send_a(8'h00);
    @(negedge clk);
    chk("gap_first_select", 32'(selA), 32'd1);
    chk("gap_hold_full_ready", 32'(rdyA), 32'd0);
    strobes_a("gap", 15);
    underrun_a("gap");

    // Enable low for 5 cycles mid-word on 3C
    push_a(8'h3C);
    send_a(8'h3C);
    @(negedge clk);
    chk("en_lat_select", 32'(selA), 32'd0);
    strobes_a("en_pre", 3);
    enA = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("en_frozen_select", 32'(selA), 32'd0);
      chk("en_frozen_busy", 32'(busyA), 32'd1);
    end
    enA = 1'b1;
    strobes_a("en_post", 5);
    underrun_a("en");

    // Reset after 3 of 8 symbols of C3, then 81 from its first bit
    push_a(8'hC3);
    send_a(8'hC3);
    @(negedge clk);
    strobes_a("rstmid", 3);
    rst = 1'b1;
    @(posedge clk); #1;
    qA.delete();
    @(negedge clk);
    chk("rstmid_select", 32'(selA), 32'd0);
    chk("rstmid_busy", 32'(busyA), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rstmid_quiet_select", 32'(selA), 32'd0);
      chk("rstmid_quiet_underrun", 32'(undA), 32'd0);
    end
    push_a(8'h81);
    send_a(8'h81);
    @(negedge clk);
    chk("r81_lat_select", 32'(selA), 32'd0);
    strobes_a("r81", 8);
    underrun_a("r81");

    // BPS=2 LSB first, one tick per 4 cycles: 1B -> 3,2,1,0
    qB.push_back(32'd3); qB.push_back(32'd2); qB.push_back(32'd1); qB.push_back(32'd0);
    send_b(8'h1B);
    n = 0;
    @(negedge clk);
    while (selB !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("b_first_strobe", 32'(selB), 32'd1);
    for (int s = 1; s < 4; s++) begin
      for (int g = 0; g < 3; g++) begin
        @(negedge clk);
        chk("b_gap_select", 32'(selB), 32'd0);
      end
      @(negedge clk);
      chk("b_period_select", 32'(selB), 32'd1);
    end
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      chk("b_tail_underrun", 32'(undB), 32'd0);
    end
    @(negedge clk);
    chk("b_underrun", 32'(undB), 32'd1);
    chk("b_idle_busy", 32'(busyB), 32'd0);

    @(negedge clk);
    chk("a_queue_drained", 32'(qA.size()), 32'd0);
    chk("b_queue_drained", 32'(qB.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
